// File: rtl/shift_seq.sv
// shift_seq -- multi-cycle shift sequencer for the ALU shift path.
//
// Accepts an operand, a shift distance and a shift kind. It then shifts the
// operand by one position per clock until the requested distance is done.
// The result is returned over a valid/ready handshake. This avoids a full
// barrel shifter at the cost of n+2 cycles per operation.
//
// Parameters
//   WIDTH      operand/result width
//   SHW        shift-amount width (max shift 2^SHW-1)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present             in_ready   can accept (IDLE)
//   B          operand                      shamt      shift distance
//   ALUfun     00 SLL, 01 SRL, 11 SRA, 10 reserved (flags err)
//   abort      synchronous cancel, highest priority
//   out_valid  result present (DONE)        out_ready  consumer accepts
//   y          result (the data register)   err        reserved-kind flag
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       ALUfun,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  localparam logic [1:0] K_SLL = 2'b00;
  localparam logic [1:0] K_SRL = 2'b01;
  localparam logic [1:0] K_RES = 2'b10;
  localparam logic [1:0] K_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   cnt;
  logic [1:0]       kind;
  logic             err_r;

  // Every output is decoded from registers only. No input reaches an
  // output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y         = data;
  assign err       = err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      kind  <= '0;
      err_r <= 1'b0;
    end else if (abort) begin
      // Cancel from any state. The data register keeps its value.
      // A simultaneous request in IDLE is dropped.
      state <= IDLE;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= B;
            cnt   <= shamt;
            kind  <= ALUfun;
            err_r <= (ALUfun == K_RES);
            // A zero distance or the reserved kind finishes at once.
            if (shamt == '0 || ALUfun == K_RES)
              state <= DONE;
            else
              state <= SHIFT;
          end
        end
        SHIFT: begin
          case (kind)
            K_SLL:   data <= {data[WIDTH-2:0], 1'b0};
            K_SRL:   data <= {1'b0, data[WIDTH-1:1]};
            K_SRA:   data <= {data[WIDTH-1], data[WIDTH-1:1]};
            default: data <= data;
          endcase
          // cnt is always >= 1 here. The guard keeps it from wrapping if
          // that ever stops being true.
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          if (cnt <= {{(SHW-1){1'b0}}, 1'b1})
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq. It runs directed steps from the test plan, then
// random operations. Each result is checked against an arithmetic reference
// model: <<, >>, and signed >>> on the operand.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] B = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  ALUfun = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .B(B), .shamt(shamt), .ALUfun(ALUfun), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_y(input logic [31:0] b, input int s, input logic [1:0] f);
    logic [31:0] r;
    case (f)
      2'b00:   r = b << s;
      2'b01:   r = b >> s;
      2'b11:   r = $unsigned($signed(b) >>> s);
      default: r = b;
    endcase
    return r;
  endfunction

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid for up to 100 edges and returns the count of
  // edges waited.
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
  endtask

  // Issues one request, then checks the latency, the result and back-pressure.
  task automatic run_op(input logic [31:0] b, input logic [4:0] s,
                        input logic [1:0] f, input int hold);
    int          k;
    int          exp_lat;
    logic [31:0] exp_y;
    exp_y   = model_y(b, int'(s), f);
    exp_lat = (s == 0 || f == 2'b10) ? 0 : int'(s);
    check("in_ready_before", {31'b0, in_ready}, 32'd1);
    B = b; shamt = s; ALUfun = f; in_valid = 1'b1;
    tick();                               // acceptance edge E0
    in_valid = 1'b0;
    B = $urandom; shamt = 5'($urandom); ALUfun = 2'($urandom);  // must be ignored
    wait_valid(k);
    check("latency", k, exp_lat);
    check("y", y, exp_y);
    check("err", {31'b0, err}, {31'b0, (f == 2'b10)});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_y", y, exp_y);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    $display("op B=%08h shamt=%0d fun=%0d -> y=%08h err=%0d lat=%0d", b, s, f, y, err, k);
  endtask

  initial begin
    int          k;
    logic [31:0] rb;
    logic [4:0]  rs;
    logic [1:0]  rf;

    // Reset state.
    #12;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_y", y, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed operations.
    run_op(32'h0000_0001, 5'd31, 2'b00, 0);
    run_op(32'h8000_00F0, 5'd4,  2'b11, 1);
    run_op(32'h8000_00F0, 5'd4,  2'b01, 0);
    run_op(32'h1234_5678, 5'd0,  2'b00, 0);
    run_op(32'hCAFE_BABE, 5'd7,  2'b10, 2);
    run_op(32'hFFFF_0000, 5'd8,  2'b01, 5);

    // Abort at SHIFT cycle 3 while in_valid stays high. The held request
    // is accepted one cycle later and completes normally.
    B = 32'h0000_0F0F; shamt = 5'd10; ALUfun = 2'b00; in_valid = 1'b1;
    tick();                               // E0
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {31'b0, in_ready}, 32'd1);
    check("abort_no_valid2", {31'b0, out_valid}, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
    tick();                               // held request accepted here
    in_valid = 1'b0;
    check("reaccept", {31'b0, in_ready}, 32'd0);
    wait_valid(k);
    check("abort_relat", k, 32'd10);
    check("abort_rey", y, 32'h0000_0F0F << 10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("abort then reissue y=%08h lat=%0d", y, k);

    // Abort coincides with the DONE handshake. Abort wins and err clears.
    B = 32'h0BAD_F00D; shamt = 5'd3; ALUfun = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("res_err", {31'b0, err}, 32'd1);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    check("abort_done_valid", {31'b0, out_valid}, 32'd0);
    check("abort_done_err", {31'b0, err}, 32'd0);
    $display("abort during DONE handshake");

    // Random operations.
    for (int n = 0; n < 24; n++) begin
      rb = $urandom;
      rs = 5'($urandom);
      rf = 2'($urandom);
      run_op(rb, rs, rf, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-shift (shamt=20).
    B = 32'hDEAD_BEEF; shamt = 5'd20; ALUfun = 2'b11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("reset mid-shift");
    run_op(32'h0000_00FF, 5'd2, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the ALU shift path. Accepts an operand, a shift amount and a shift kind, then drives the one-position shift stage once per clock until the requested distance is covered. Returns the result over a valid/ready handshake. Used wherever a full barrel shifter is too costly: the ALU issues SLL/SRL/SRA here and stalls until `out_valid`.

## Interface
- `WIDTH`, 32, operand/result width
- `SHW`, 5, shift-amount width; the maximum shift is 2^SHW-1
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  sequencer can accept a request
- `B`  in  WIDTH  operand to shift
- `shamt`  in  SHW  shift distance
- `ALUfun`  in  2  shift kind: 00 SLL, 01 SRL, 11 SRA, 10 reserved
- `abort`  in  1  synchronous cancel of the current operation
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `y`  out  WIDTH  shifted result
- `err`  out  1  result came from a reserved ALUfun; valid only with `out_valid`

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers: `data` (WIDTH), `cnt` (SHW), `kind` (2), `err_r`.
- `in_ready` is 1 only in IDLE.
- `out_valid` is 1 only in DONE.
- `y` = `data` at all times.
- `err` = `err_r`.

**IDLE**
- On `in_valid`: load `data<=B`, `cnt<=shamt`, `kind<=ALUfun`, `err_r<=(ALUfun==2'b10)`.
- Go to DONE if `shamt==0` or `ALUfun==2'b10`; otherwise go to SHIFT.

**SHIFT**
- Each edge, `data` is replaced by its one-position shift of kind `kind`:
  - SLL: `{data[W-2:0],0}`
  - SRL: `{0,data[W-1:1]}`
  - SRA: `{data[W-1],data[W-1:1]}`
- `cnt<=cnt-1`. When `cnt==1` on that edge, go to DONE.
- `cnt` never wraps; it is never decremented at 0.

**DONE**
- Hold `data` and `err_r` stable while `out_ready` is 0.
- On `out_ready`, go to IDLE.

**abort** (highest priority, any state)
- Next state is IDLE and `err_r<=0`.
- `data` is not cleared.
- A simultaneous `in_valid` in IDLE is not accepted.

**Reset** (asynchronous, any time, including mid-shift)
- State goes to IDLE; `data`, `cnt`, `kind` and `err_r` go to 0.
- Outputs: `in_ready=1`, `out_valid=0`, `y=0`, `err=0`.

**Arithmetic and inputs**
- The shift distance is unsigned, 0..2^SHW-1.
- `B`, `shamt` and `ALUfun` are sampled only on the accepting edge; later changes are ignored.

## Timing
- Acceptance edge E0: `in_valid & in_ready` high at a rising edge.
- Latency: `out_valid` rises after edge E0+n for n=`shamt`>0, or after E0 for n=0 or reserved ALUfun.
- The result is held until the first edge with `out_ready=1`. `out_valid` drops after that edge and `in_ready` rises in the same cycle.
- Minimum issue interval: n+2 cycles when `out_ready` is held high.
- No combinational path from `in_valid`, `out_ready` or `abort` to any output. All outputs are decoded from registers.
- `abort` in the same cycle as a DONE handshake: abort wins. The result counts as consumed and `out_valid` is 0 next cycle.

## Test plan
- **Reset:** assert `rst_n=0` mid-SHIFT with `shamt=20` -> outputs drop immediately to `in_ready=1`, `out_valid=0`, `y=0`, `err=0`.
- **SLL:** `B=0x0000_0001`, `shamt=31`, `ALUfun=00` -> `out_valid` after E0+31, `y=0x8000_0000`, `err=0`.
- **SRA:** `B=0x8000_00F0`, `shamt=4`, `ALUfun=11` -> `y=0xF800_000F` after E0+4. The same operand with `ALUfun=01` -> `y=0x0800_000F`.
- **Zero shift and reserved kind:** `shamt=0`, `B=0x1234_5678` -> `y=0x1234_5678` after E0. `ALUfun=10`, `shamt=7` -> `y=B`, `err=1` after E0.
- **Back-pressure:** `B=0xFFFF_0000`, `shamt=8`, `ALUfun=01`, with `out_ready=0` for 5 cycles in DONE -> `y=0x00FF_FF00` held stable, `in_ready=0`; the next request is accepted only after the `out_ready` edge.
- **Abort:** `abort` at SHIFT cycle 3 of `shamt=10`, with `in_valid` held high -> IDLE next edge, no `out_valid` pulse; the held request is accepted one cycle later and completes normally.
